// File: rtl/l2cache_pkg.sv
// Shared definitions for the L2 cache controller: FSM states, request
// source codes and cache-maintenance opcodes.
package l2cache_pkg;

    typedef enum logic [3:0] {
        S_IDLE         = 4'd0,
        S_LOOKUP       = 4'd1,
        S_OP           = 4'd2,
        S_CHK_DIRTY    = 4'd3,
        S_WB           = 4'd4,
        S_REFILL_REQ   = 4'd5,
        S_REFILL_WAIT  = 4'd6,
        S_REFILL_WRITE = 4'd7,
        S_SUC_W        = 4'd8
    } state_t;

    // Request source encoding, shared by req_from and rbuf_from.
    localparam logic [1:0] SRC_NONE = 2'b00;
    localparam logic [1:0] SRC_IRD  = 2'b01;
    localparam logic [1:0] SRC_DRD  = 2'b10;
    localparam logic [1:0] SRC_DWR  = 2'b11;

    // Cache-maintenance opcodes; the unused code 3 behaves as OPC_INIT.
    localparam logic [1:0] OPC_INIT    = 2'd0;
    localparam logic [1:0] OPC_INV_IDX = 2'd1;
    localparam logic [1:0] OPC_HIT_INV = 2'd2;

endpackage

// File: rtl/l2cache_prio_enc.sv
// Lowest-set-bit encoder: turns the per-way hit vector into a way index.
module l2cache_prio_enc
    import l2cache_pkg::*;
#(
    parameter int WAYS  = 4,
    parameter int IDX_W = $clog2(WAYS)
) (
    input  logic [WAYS-1:0]  i_vec,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        o_idx   = {IDX_W{1'b0}};
        o_valid = |i_vec;
        for (int i = WAYS - 1; i >= 0; i--) begin
            o_idx = i_vec[i] ? IDX_W'(i) : o_idx;
        end
    end

endmodule

// File: rtl/l2cache_fsm_ctrl.sv
// L2 cache control FSM: lookup, hit pipelining, dirty writeback, refill,
// strongly-ordered accesses and cache-maintenance ops. All outputs are
// decoded combinationally from the current state and inputs.
module l2cache_fsm_ctrl
    import l2cache_pkg::*;
#(
    parameter int WAYS   = 4,
    parameter int WAY_W  = $clog2(WAYS),
    parameter int PAR_WB = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_from,
    input  logic             req_op,
    output logic             icache_addr_ok,
    output logic             icache_data_ok,
    output logic             dcache_addr_ok,
    output logic             dcache_data_ok,
    output logic             mem_req_r,
    output logic             mem_req_w,
    output logic             mem_rdy,
    input  logic             mem_addr_ok_r,
    input  logic             mem_addr_ok_w,
    input  logic             mem_data_ok,
    output logic             rbuf_we,
    input  logic [1:0]       rbuf_from,
    input  logic             rbuf_op,
    input  logic [1:0]       rbuf_opcode,
    input  logic [WAY_W-1:0] rbuf_way,
    input  logic             rbuf_suc,
    input  logic [WAYS-1:0]  hit,
    input  logic [WAY_W-1:0] victim_way,
    input  logic             dirty,
    output logic [WAYS-1:0]  use_way,
    output logic [WAYS-1:0]  data_we,
    output logic [WAYS-1:0]  tagv_inval,
    output logic             tagv_init,
    output logic             data_refill,
    output logic             data_wb,
    output logic             dirty_set,
    output logic             dirty_clr,
    output logic             choose_return,
    output logic [WAY_W-1:0] sel_way
);

    localparam logic PAR_EN = (PAR_WB != 0);

    state_t             r_state;
    state_t             w_next;
    logic [WAY_W-1:0]   r_vway;
    logic [WAY_W-1:0]   w_vway_nx;
    logic               r_rd_acc;
    logic               w_rd_acc_nx;
    logic [WAY_W-1:0]   w_hit_idx;
    logic               w_any_hit;
    logic               w_new_req;
    logic               w_cap_iok;
    logic               w_cap_dok;
    logic               w_src_ird;
    logic               w_src_drd;
    logic               w_src_dwr;

    function automatic logic [WAYS-1:0] way_onehot(input logic [WAY_W-1:0] idx);
        way_onehot = {{(WAYS-1){1'b0}}, 1'b1} << idx;
    endfunction

    l2cache_prio_enc #(
        .WAYS  (WAYS),
        .IDX_W (WAY_W)
    ) u_hit_enc (
        .i_vec   (hit),
        .o_idx   (w_hit_idx),
        .o_valid (w_any_hit)
    );

    // A new request is accepted only when no cache op is pending; the
    // dcache address handshake is held back for strongly-ordered traffic.
    assign w_new_req = (req_from != SRC_NONE);
    assign w_cap_iok = (req_from == SRC_IRD);
    assign w_cap_dok = req_from[1] & ~rbuf_suc;
    assign w_src_ird = (rbuf_from == SRC_IRD);
    assign w_src_drd = (rbuf_from == SRC_DRD);
    assign w_src_dwr = (rbuf_from == SRC_DWR);

    // State, latched victim way and early-read-accept flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_vway   <= {WAY_W{1'b0}};
            r_rd_acc <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_vway   <= w_vway_nx;
            r_rd_acc <= w_rd_acc_nx;
        end
    end

    // Next-state and output decode; reset holds every output at zero.
    always_comb begin
        w_next         = r_state;
        w_vway_nx      = r_vway;
        w_rd_acc_nx    = r_rd_acc;
        icache_addr_ok = 1'b0;
        icache_data_ok = 1'b0;
        dcache_addr_ok = 1'b0;
        dcache_data_ok = 1'b0;
        mem_req_r      = 1'b0;
        mem_req_w      = 1'b0;
        mem_rdy        = 1'b0;
        rbuf_we        = 1'b0;
        use_way        = {WAYS{1'b0}};
        data_we        = {WAYS{1'b0}};
        tagv_inval     = {WAYS{1'b0}};
        tagv_init      = 1'b0;
        data_refill    = 1'b0;
        data_wb        = 1'b0;
        dirty_set      = 1'b0;
        dirty_clr      = 1'b0;
        choose_return  = 1'b0;
        sel_way        = {WAY_W{1'b0}};

        if (rst) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_op) begin
                        w_next = S_OP;
                    end else if (w_new_req) begin
                        rbuf_we        = 1'b1;
                        icache_addr_ok = w_cap_iok;
                        dcache_addr_ok = w_cap_dok;
                        w_next         = S_LOOKUP;
                    end else begin
                        w_next = S_IDLE;
                    end
                end

                S_LOOKUP: begin
                    if (rbuf_suc) begin
                        w_next = w_src_dwr ? S_SUC_W : S_REFILL_REQ;
                    end else if (w_any_hit) begin
                        use_way        = way_onehot(w_hit_idx);
                        sel_way        = w_hit_idx;
                        icache_data_ok = w_src_ird;
                        dcache_data_ok = w_src_drd;
                        data_we        = w_src_dwr ? way_onehot(w_hit_idx) : {WAYS{1'b0}};
                        dirty_set      = w_src_dwr;
                        // Hit pipelining: accept the next request while serving this hit.
                        if (w_new_req && !req_op) begin
                            rbuf_we        = 1'b1;
                            icache_addr_ok = w_cap_iok;
                            dcache_addr_ok = w_cap_dok;
                            w_next         = S_LOOKUP;
                        end else begin
                            w_next = S_IDLE;
                        end
                    end else begin
                        w_vway_nx = victim_way;
                        w_next    = S_CHK_DIRTY;
                    end
                end

                S_OP: begin
                    case (rbuf_opcode)
                        OPC_INV_IDX: begin
                            tagv_inval = way_onehot(rbuf_way);
                            w_vway_nx  = rbuf_way;
                            w_next     = S_CHK_DIRTY;
                        end
                        OPC_HIT_INV: begin
                            if (w_any_hit) begin
                                tagv_inval = way_onehot(w_hit_idx);
                                w_vway_nx  = w_hit_idx;
                                w_next     = S_CHK_DIRTY;
                            end else begin
                                w_next = S_IDLE;
                            end
                        end
                        default: begin
                            tagv_init = 1'b1;
                            sel_way   = rbuf_way;
                            w_next    = S_IDLE;
                        end
                    endcase
                end

                S_CHK_DIRTY: begin
                    sel_way = r_vway;
                    if (dirty) begin
                        data_wb = 1'b1;
                        w_next  = S_WB;
                    end else begin
                        w_next = rbuf_op ? S_IDLE : S_REFILL_REQ;
                    end
                end

                S_WB: begin
                    mem_req_w = 1'b1;
                    data_wb   = 1'b1;
                    sel_way   = r_vway;
                    // Overlapped refill read: remember an early read acceptance.
                    if (PAR_EN && !rbuf_op) begin
                        mem_req_r   = 1'b1;
                        w_rd_acc_nx = r_rd_acc | mem_addr_ok_r;
                    end else begin
                        w_rd_acc_nx = r_rd_acc;
                    end
                    if (mem_addr_ok_w) begin
                        w_rd_acc_nx = 1'b0;
                        if (rbuf_op) begin
                            w_next = S_IDLE;
                        end else if (r_rd_acc || (PAR_EN && mem_addr_ok_r)) begin
                            w_next = S_REFILL_WAIT;
                        end else begin
                            w_next = S_REFILL_REQ;
                        end
                    end else begin
                        w_next = S_WB;
                    end
                end

                S_REFILL_REQ: begin
                    mem_req_r = 1'b1;
                    w_next    = (mem_addr_ok_r || mem_data_ok) ? S_REFILL_WAIT : S_REFILL_REQ;
                end

                S_REFILL_WAIT: begin
                    mem_rdy = 1'b1;
                    if (mem_data_ok) begin
                        choose_return = 1'b1;
                        if (rbuf_suc) begin
                            rbuf_we        = 1'b1;
                            icache_data_ok = w_src_ird;
                            dcache_data_ok = w_src_drd;
                            w_next         = S_IDLE;
                        end else if (w_src_dwr) begin
                            data_refill = 1'b1;
                            data_we     = way_onehot(r_vway);
                            sel_way     = r_vway;
                            w_next      = S_REFILL_WRITE;
                        end else begin
                            data_refill    = 1'b1;
                            data_we        = way_onehot(r_vway);
                            sel_way        = r_vway;
                            use_way        = way_onehot(r_vway);
                            dirty_clr      = 1'b1;
                            rbuf_we        = 1'b1;
                            icache_data_ok = w_src_ird;
                            dcache_data_ok = w_src_drd;
                            w_next         = S_IDLE;
                        end
                    end else begin
                        w_next = S_REFILL_WAIT;
                    end
                end

                S_REFILL_WRITE: begin
                    data_we   = way_onehot(r_vway);
                    use_way   = way_onehot(r_vway);
                    dirty_set = 1'b1;
                    sel_way   = r_vway;
                    w_next    = S_IDLE;
                end

                S_SUC_W: begin
                    mem_req_w = 1'b1;
                    if (mem_addr_ok_w) begin
                        dcache_addr_ok = 1'b1;
                        w_next         = S_IDLE;
                    end else begin
                        w_next = S_SUC_W;
                    end
                end

                default: begin
                    w_next = S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_l2cache_fsm_ctrl.sv
// Directed scoreboard bench: an 8-way controller (serial writeback) and a
// 4-way controller (overlapped refill read) share one stimulus stream.
module tb_l2cache_fsm_ctrl;
    import l2cache_pkg::*;

    typedef struct packed {
        state_t     st;
        logic       ia, id, da, dd, mr, mw, rdy, rwe;
        logic [7:0] uw, we, inv;
        logic       init, refill, wb, dset, dclr, cret;
        logic [2:0] sel;
    } obs_t;

    typedef struct {
        bit    which;
        string tag;
        obs_t  exp;
    } sb_t;

    logic       clk, rst;
    logic [1:0] req_from, rbuf_from, rbuf_opcode;
    logic       req_op, mem_addr_ok_r, mem_addr_ok_w, mem_data_ok;
    logic       rbuf_op, rbuf_suc, dirty;
    logic [2:0] rbuf_way, victim_way;
    logic [7:0] hit;

    logic       a_ia, a_id, a_da, a_dd, a_mr, a_mw, a_rdy, a_rwe;
    logic [7:0] a_uw, a_we, a_inv;
    logic       a_init, a_refill, a_wb, a_dset, a_dclr, a_cret;
    logic [2:0] a_sel;

    logic       b_ia, b_id, b_da, b_dd, b_mr, b_mw, b_rdy, b_rwe;
    logic [3:0] b_uw, b_we, b_inv;
    logic       b_init, b_refill, b_wb, b_dset, b_dclr, b_cret;
    logic [1:0] b_sel;

    sb_t sb_q[$];
    int  total = 0;
    int  bad   = 0;

    l2cache_fsm_ctrl #(.WAYS(8), .PAR_WB(0)) dut_a (
        .clk(clk), .rst(rst), .req_from(req_from), .req_op(req_op),
        .icache_addr_ok(a_ia), .icache_data_ok(a_id),
        .dcache_addr_ok(a_da), .dcache_data_ok(a_dd),
        .mem_req_r(a_mr), .mem_req_w(a_mw), .mem_rdy(a_rdy),
        .mem_addr_ok_r(mem_addr_ok_r), .mem_addr_ok_w(mem_addr_ok_w), .mem_data_ok(mem_data_ok),
        .rbuf_we(a_rwe), .rbuf_from(rbuf_from), .rbuf_op(rbuf_op), .rbuf_opcode(rbuf_opcode),
        .rbuf_way(rbuf_way), .rbuf_suc(rbuf_suc), .hit(hit), .victim_way(victim_way), .dirty(dirty),
        .use_way(a_uw), .data_we(a_we), .tagv_inval(a_inv), .tagv_init(a_init),
        .data_refill(a_refill), .data_wb(a_wb), .dirty_set(a_dset), .dirty_clr(a_dclr),
        .choose_return(a_cret), .sel_way(a_sel)
    );

    l2cache_fsm_ctrl #(.WAYS(4), .PAR_WB(1)) dut_b (
        .clk(clk), .rst(rst), .req_from(req_from), .req_op(req_op),
        .icache_addr_ok(b_ia), .icache_data_ok(b_id),
        .dcache_addr_ok(b_da), .dcache_data_ok(b_dd),
        .mem_req_r(b_mr), .mem_req_w(b_mw), .mem_rdy(b_rdy),
        .mem_addr_ok_r(mem_addr_ok_r), .mem_addr_ok_w(mem_addr_ok_w), .mem_data_ok(mem_data_ok),
        .rbuf_we(b_rwe), .rbuf_from(rbuf_from), .rbuf_op(rbuf_op), .rbuf_opcode(rbuf_opcode),
        .rbuf_way(rbuf_way[1:0]), .rbuf_suc(rbuf_suc), .hit(hit[3:0]),
        .victim_way(victim_way[1:0]), .dirty(dirty),
        .use_way(b_uw), .data_we(b_we), .tagv_inval(b_inv), .tagv_init(b_init),
        .data_refill(b_refill), .data_wb(b_wb), .dirty_set(b_dset), .dirty_clr(b_dclr),
        .choose_return(b_cret), .sel_way(b_sel)
    );

    // 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Absolute time limit so the run can never hang.
    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic obs_t samp_a();
        obs_t o;
        o.st = dut_a.r_state;
        o.ia = a_ia; o.id = a_id; o.da = a_da; o.dd = a_dd;
        o.mr = a_mr; o.mw = a_mw; o.rdy = a_rdy; o.rwe = a_rwe;
        o.uw = a_uw; o.we = a_we; o.inv = a_inv;
        o.init = a_init; o.refill = a_refill; o.wb = a_wb;
        o.dset = a_dset; o.dclr = a_dclr; o.cret = a_cret; o.sel = a_sel;
        return o;
    endfunction

    function automatic obs_t samp_b();
        obs_t o;
        o.st = dut_b.r_state;
        o.ia = b_ia; o.id = b_id; o.da = b_da; o.dd = b_dd;
        o.mr = b_mr; o.mw = b_mw; o.rdy = b_rdy; o.rwe = b_rwe;
        o.uw = {4'h0, b_uw}; o.we = {4'h0, b_we}; o.inv = {4'h0, b_inv};
        o.init = b_init; o.refill = b_refill; o.wb = b_wb;
        o.dset = b_dset; o.dclr = b_dclr; o.cret = b_cret; o.sel = {1'b0, b_sel};
        return o;
    endfunction

    function automatic obs_t ex(input state_t s);
        obs_t e;
        e = '0;
        e.st = s;
        return e;
    endfunction

    task automatic clr();
        req_from = 2'b00; req_op = 1'b0;
        mem_addr_ok_r = 1'b0; mem_addr_ok_w = 1'b0; mem_data_ok = 1'b0;
        rbuf_from = 2'b00; rbuf_op = 1'b0; rbuf_opcode = 2'd0; rbuf_way = 3'd0;
        rbuf_suc = 1'b0; hit = 8'h00; victim_way = 3'd0; dirty = 1'b0;
    endtask

    task automatic check_front();
        sb_t  ent;
        obs_t got;
        ent = sb_q.pop_front();
        got = ent.which ? samp_b() : samp_a();
        total++;
        assert (got === ent.exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", ent.tag, got, ent.exp);
        end
    endtask

    // Push the expectation for the current inputs, compare mid-cycle, advance.
    task automatic step(input bit which, input string tag, input obs_t e);
        sb_t ent;
        ent.which = which;
        ent.tag   = tag;
        ent.exp   = e;
        sb_q.push_back(ent);
        #2;
        check_front();
        @(posedge clk);
        #1;
    endtask

    initial begin
        obs_t e;
        rst = 1'b1;
        clr();
        req_from = SRC_DRD;
        @(posedge clk);
        #1;
        // Reset holds IDLE with all outputs low despite a pending request.
        step(1'b0, "rst_a", ex(S_IDLE));
        step(1'b1, "rst_b", ex(S_IDLE));
        rst = 1'b0;

        // 8-way dcache read hit, lowest hit bit selects way 2.
        clr(); req_from = SRC_DRD;
        e = ex(S_IDLE); e.da = 1'b1; e.rwe = 1'b1; step(1'b0, "rd_cap", e);
        clr(); rbuf_from = SRC_DRD; hit = 8'b0010_0100;
        e = ex(S_LOOKUP); e.uw = 8'h04; e.sel = 3'd2; e.dd = 1'b1; step(1'b0, "rd_hit", e);
        clr(); step(1'b0, "rd_idle", ex(S_IDLE));

        // Back-to-back icache hits with req_from held.
        req_from = SRC_IRD;
        e = ex(S_IDLE); e.ia = 1'b1; e.rwe = 1'b1; step(1'b0, "ic_cap", e);
        rbuf_from = SRC_IRD; hit = 8'h01;
        e = ex(S_LOOKUP); e.ia = 1'b1; e.id = 1'b1; e.rwe = 1'b1; e.uw = 8'h01; e.sel = 3'd0;
        step(1'b0, "ic_pipe0", e);
        hit = 8'h10;
        e = ex(S_LOOKUP); e.ia = 1'b1; e.id = 1'b1; e.rwe = 1'b1; e.uw = 8'h10; e.sel = 3'd4;
        step(1'b0, "ic_pipe1", e);
        req_from = SRC_NONE; hit = 8'h06;
        e = ex(S_LOOKUP); e.id = 1'b1; e.uw = 8'h02; e.sel = 3'd1; step(1'b0, "ic_last", e);
        clr(); step(1'b0, "ic_idle", ex(S_IDLE));

        // Write miss on dirty victim 3, serial writeback then refill.
        req_from = SRC_DWR;
        e = ex(S_IDLE); e.da = 1'b1; e.rwe = 1'b1; step(1'b0, "wm_cap", e);
        clr(); rbuf_from = SRC_DWR; victim_way = 3'd3;
        step(1'b0, "wm_lookup", ex(S_LOOKUP));
        victim_way = 3'd5; dirty = 1'b1;
        e = ex(S_CHK_DIRTY); e.sel = 3'd3; e.wb = 1'b1; step(1'b0, "wm_chk", e);
        dirty = 1'b0;
        e = ex(S_WB); e.mw = 1'b1; e.wb = 1'b1; e.sel = 3'd3; step(1'b0, "wm_wb0", e);
        mem_addr_ok_w = 1'b1; mem_addr_ok_r = 1'b1;
        step(1'b0, "wm_wb_ack", e);
        mem_addr_ok_w = 1'b0; mem_addr_ok_r = 1'b0;
        e = ex(S_REFILL_REQ); e.mr = 1'b1; step(1'b0, "wm_rreq0", e);
        mem_addr_ok_r = 1'b1; step(1'b0, "wm_rreq_ack", e);
        mem_addr_ok_r = 1'b0;
        e = ex(S_REFILL_WAIT); e.rdy = 1'b1; step(1'b0, "wm_wait", e);
        mem_data_ok = 1'b1;
        e = ex(S_REFILL_WAIT); e.rdy = 1'b1; e.cret = 1'b1; e.refill = 1'b1;
        e.we = 8'h08; e.sel = 3'd3; step(1'b0, "wm_data", e);
        mem_data_ok = 1'b0;
        e = ex(S_REFILL_WRITE); e.we = 8'h08; e.uw = 8'h08; e.dset = 1'b1; e.sel = 3'd3;
        step(1'b0, "wm_write", e);
        clr(); step(1'b0, "wm_idle", ex(S_IDLE));

        // Cache ops: hit-invalidate miss, invalidate-by-index, opcode 3.
        req_op = 1'b1; req_from = SRC_IRD; step(1'b0, "op2_cap", ex(S_IDLE));
        clr(); rbuf_op = 1'b1; rbuf_opcode = 2'd2;
        step(1'b0, "op2_nohit", ex(S_OP));
        clr(); step(1'b0, "op2_idle", ex(S_IDLE));
        req_op = 1'b1; step(1'b0, "op1_cap", ex(S_IDLE));
        clr(); rbuf_op = 1'b1; rbuf_opcode = 2'd1; rbuf_way = 3'd6;
        e = ex(S_OP); e.inv = 8'h40; step(1'b0, "op1", e);
        rbuf_way = 3'd0;
        e = ex(S_CHK_DIRTY); e.sel = 3'd6; step(1'b0, "op1_chk", e);
        clr(); step(1'b0, "op1_idle", ex(S_IDLE));
        req_op = 1'b1; step(1'b0, "op3_cap", ex(S_IDLE));
        clr(); rbuf_op = 1'b1; rbuf_opcode = 2'd3; rbuf_way = 3'd5;
        e = ex(S_OP); e.init = 1'b1; e.sel = 3'd5; step(1'b0, "op3", e);
        clr(); step(1'b0, "op3_idle", ex(S_IDLE));

        // Strongly-ordered write: dcache_addr_ok only on the write accept.
        req_from = SRC_DWR; rbuf_suc = 1'b1;
        e = ex(S_IDLE); e.rwe = 1'b1; step(1'b0, "suc_cap", e);
        clr(); rbuf_from = SRC_DWR; rbuf_suc = 1'b1;
        step(1'b0, "suc_lookup", ex(S_LOOKUP));
        e = ex(S_SUC_W); e.mw = 1'b1; step(1'b0, "suc_w0", e);
        mem_addr_ok_w = 1'b1;
        e = ex(S_SUC_W); e.mw = 1'b1; e.da = 1'b1; step(1'b0, "suc_w_ack", e);
        clr(); step(1'b0, "suc_idle", ex(S_IDLE));

        // Reset in REFILL_WAIT: outputs drop, later data is ignored.
        req_from = SRC_DRD;
        e = ex(S_IDLE); e.da = 1'b1; e.rwe = 1'b1; step(1'b0, "rs_cap", e);
        clr(); rbuf_from = SRC_DRD; rbuf_suc = 1'b1;
        step(1'b0, "rs_lookup", ex(S_LOOKUP));
        mem_addr_ok_r = 1'b1;
        e = ex(S_REFILL_REQ); e.mr = 1'b1; step(1'b0, "rs_rreq", e);
        mem_addr_ok_r = 1'b0;
        e = ex(S_REFILL_WAIT); e.rdy = 1'b1; step(1'b0, "rs_wait", e);
        rst = 1'b1; step(1'b0, "rs_rst", ex(S_REFILL_WAIT));
        rst = 1'b0; mem_data_ok = 1'b1;
        step(1'b0, "rs_late_data", ex(S_IDLE));
        clr(); step(1'b0, "rs_idle", ex(S_IDLE));

        // Overlapped refill read: read accepted before write, REFILL_REQ skipped.
        rst = 1'b1; step(1'b1, "par_rst", ex(S_IDLE));
        rst = 1'b0; req_from = SRC_DRD;
        e = ex(S_IDLE); e.da = 1'b1; e.rwe = 1'b1; step(1'b1, "par_cap", e);
        clr(); rbuf_from = SRC_DRD; victim_way = 3'd1;
        step(1'b1, "par_lookup", ex(S_LOOKUP));
        dirty = 1'b1;
        e = ex(S_CHK_DIRTY); e.sel = 3'd1; e.wb = 1'b1; step(1'b1, "par_chk", e);
        dirty = 1'b0; mem_addr_ok_r = 1'b1;
        e = ex(S_WB); e.mw = 1'b1; e.mr = 1'b1; e.wb = 1'b1; e.sel = 3'd1;
        step(1'b1, "par_wb_racc", e);
        mem_addr_ok_r = 1'b0; mem_addr_ok_w = 1'b1;
        step(1'b1, "par_wb_wack", e);
        mem_addr_ok_w = 1'b0;
        e = ex(S_REFILL_WAIT); e.rdy = 1'b1; step(1'b1, "par_wait", e);
        mem_data_ok = 1'b1;
        e = ex(S_REFILL_WAIT); e.rdy = 1'b1; e.cret = 1'b1; e.refill = 1'b1;
        e.we = 8'h02; e.uw = 8'h02; e.dclr = 1'b1; e.rwe = 1'b1; e.dd = 1'b1; e.sel = 3'd1;
        step(1'b1, "par_data", e);
        clr(); step(1'b1, "par_idle", ex(S_IDLE));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
